// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: default widths and
// the fixed requester slot assignment.
package reg_wb_arbiter_pkg;

   localparam int unsigned WB_DATA_WIDTH = 32;
   localparam int unsigned WB_ADDR_WIDTH = 5;
   localparam int unsigned WB_ADDR_NUM   = 2 ** WB_ADDR_WIDTH;

   localparam int unsigned WB_ALU = 0;
   localparam int unsigned WB_LSU = 1;
   localparam int unsigned WB_MUL = 2;

endpackage

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr with wraparound;
// ptr moves past the winner only when the grant is taken.
module reg_wb_arbiter_rr_arbiter #(
   parameter int unsigned NREQ = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   input  logic            advance
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0] ptr_q, ptr_d, win;
   logic          found;
   int            idx;

   always_comb begin
      grant = '0;
      win   = ptr_q;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < int'(NREQ); k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = PW'(idx);
         end
      end
      // Nothing is accepted while in reset, so pending valids are dropped.
      if (rst) grant = '0;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: round-robin shares the reg_file write port, registers the
// winning write, and tracks a busy scoreboard for RAW hazard detection.
module reg_wb_arbiter
   import reg_wb_arbiter_pkg::*;
#(
   parameter int unsigned NREQ       = 3,
   parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   output logic [NREQ-1:0]            req_ready,
   input  logic [NREQ*ADDR_WIDTH-1:0] req_waddr,
   input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
   output logic                       rf_wen,
   output logic [ADDR_WIDTH-1:0]      rf_waddr,
   output logic [DATA_WIDTH-1:0]      rf_wdata,
   input  logic                       issue_valid,
   input  logic [ADDR_WIDTH-1:0]      issue_rd,
   input  logic [ADDR_WIDTH-1:0]      chk_raddr1,
   input  logic [ADDR_WIDTH-1:0]      chk_raddr2,
   output logic                       hazard1,
   output logic                       hazard2,
   output logic [2**ADDR_WIDTH-1:0]   busy
);

   localparam int unsigned ADDR_NUM = 2 ** ADDR_WIDTH;

   logic [NREQ-1:0]       grant;
   logic                  transfer;
   logic [ADDR_WIDTH-1:0] sel_waddr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   logic                  rf_wen_q;
   logic [ADDR_WIDTH-1:0] rf_waddr_q;
   logic [DATA_WIDTH-1:0] rf_wdata_q;
   logic [ADDR_NUM-1:0]   busy_q;

   reg_wb_arbiter_rr_arbiter #(
      .NREQ(NREQ)
   ) u_rr_arbiter (
      .clk    (clk),
      .rst    (rst),
      .req    (req_valid),
      .grant  (grant),
      .advance(transfer)
   );

   assign req_ready = grant;
   assign transfer  = |(req_valid & grant);

   always_comb begin
      sel_waddr = '0;
      sel_wdata = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant[i]) begin
            sel_waddr = req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Writes to x0 are accepted from the requester but never reach the reg_file.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else if (transfer) begin
         rf_wen_q   <= (sel_waddr != '0);
         rf_waddr_q <= sel_waddr;
         rf_wdata_q <= sel_wdata;
      end else begin
         rf_wen_q   <= 1'b0;
      end
   end

   // A new issue to r outranks a retiring write to r: the newer producer owns it.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q[0] <= 1'b0;
         for (int r = 1; r < int'(ADDR_NUM); r++) begin
            if (issue_valid && (issue_rd == ADDR_WIDTH'(r))) begin
               busy_q[r] <= 1'b1;
            end else if (rf_wen_q && (rf_waddr_q == ADDR_WIDTH'(r))) begin
               busy_q[r] <= 1'b0;
            end
         end
      end
   end

   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign busy     = busy_q;
   assign hazard1  = busy_q[chk_raddr1];
   assign hazard2  = busy_q[chk_raddr2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: reset, round robin, x0 writes, scoreboard
// set/clear and a mid-operation reset.
module tb_reg_wb_arbiter;
   import reg_wb_arbiter_pkg::*;

   localparam int unsigned N  = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_waddr;
   logic [N*DW-1:0] req_wdata;
   logic            rf_wen;
   logic [AW-1:0]   rf_waddr;
   logic [DW-1:0]   rf_wdata;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic [AW-1:0]   chk_raddr1;
   logic [AW-1:0]   chk_raddr2;
   logic            hazard1;
   logic            hazard2;
   logic [31:0]     busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   reg_wb_arbiter #(
      .NREQ      (N),
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_waddr  (req_waddr),
      .req_wdata  (req_wdata),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .issue_valid(issue_valid),
      .issue_rd   (issue_rd),
      .chk_raddr1 (chk_raddr1),
      .chk_raddr2 (chk_raddr2),
      .hazard1    (hazard1),
      .hazard2    (hazard2),
      .busy       (busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one full cycle and land on the falling edge, away from posedge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst         = 1'b1;
      req_valid   = 3'b111;
      req_waddr   = '0;
      req_wdata   = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      chk_raddr1  = '0;
      chk_raddr2  = '0;
      req_waddr[WB_ALU*AW +: AW] = 5'd3;
      req_waddr[WB_LSU*AW +: AW] = 5'd4;
      req_waddr[WB_MUL*AW +: AW] = 5'd6;
      req_wdata[WB_ALU*DW +: DW] = 32'hAAAA_0000;
      req_wdata[WB_LSU*DW +: DW] = 32'hBBBB_1111;
      req_wdata[WB_MUL*DW +: DW] = 32'hCCCC_2222;

      // Reset held two cycles with all requesters valid.
      @(negedge clk);
      #1 chk("rst_ready_0", req_ready, 3'b000);
      cyc();
      chk("rst_ready_1", req_ready, 3'b000);
      chk("rst_wen", rf_wen, 1'b0);
      chk("rst_busy", busy, 32'h0);
      cyc();
      chk("rst_waddr", rf_waddr, 5'd0);
      chk("rst_wdata", rf_wdata, 32'h0);
      rst = 1'b0;
      #1 chk("post_rst_ready", req_ready, 3'b001);

      // Round robin with all three valid.
      cyc();
      chk("rr_wen_1", rf_wen, 1'b1);
      chk("rr_waddr_1", rf_waddr, 5'd3);
      chk("rr_wdata_1", rf_wdata, 32'hAAAA_0000);
      chk("rr_ready_2", req_ready, 3'b010);
      cyc();
      chk("rr_waddr_2", rf_waddr, 5'd4);
      chk("rr_ready_3", req_ready, 3'b100);
      cyc();
      chk("rr_waddr_3", rf_waddr, 5'd6);
      chk("rr_wdata_3", rf_wdata, 32'hCCCC_2222);
      chk("rr_ready_4", req_ready, 3'b001);
      cyc();
      req_valid = 3'b000;
      #1;
      chk("rr_wen_4", rf_wen, 1'b1);
      chk("rr_waddr_4", rf_waddr, 5'd3);
      chk("idle_ready", req_ready, 3'b000);
      cyc();
      chk("idle_wen", rf_wen, 1'b0);
      chk("idle_hold_waddr", rf_waddr, 5'd3);
      chk("idle_hold_wdata", rf_wdata, 32'hAAAA_0000);

      // Single write from the LSU; ptr is at 1.
      req_valid = 3'b010;
      req_waddr[WB_LSU*AW +: AW] = 5'd5;
      req_wdata[WB_LSU*DW +: DW] = 32'hDEAD_BEEF;
      #1 chk("single_ready", req_ready, 3'b010);
      cyc();
      req_valid = 3'b000;
      chk("single_wen", rf_wen, 1'b1);
      chk("single_waddr", rf_waddr, 5'd5);
      chk("single_wdata", rf_wdata, 32'hDEAD_BEEF);

      // x0 write from ALU; ptr is at 2 so the search wraps to 0.
      req_valid = 3'b001;
      req_waddr[WB_ALU*AW +: AW] = 5'd0;
      #1 chk("x0_ready", req_ready, 3'b001);
      cyc();
      req_valid = 3'b000;
      chk("x0_wen", rf_wen, 1'b0);
      chk("x0_busy", busy, 32'h0);

      // Scoreboard set then clear on write-back; ptr is at 1.
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      chk_raddr1  = 5'd7;
      #1 chk("sb_hazard_before", hazard1, 1'b0);
      cyc();
      issue_valid = 1'b0;
      #1;
      chk("sb_hazard_set", hazard1, 1'b1);
      chk("sb_busy_set", busy, 32'h0000_0080);
      req_valid = 3'b100;
      req_waddr[WB_MUL*AW +: AW] = 5'd7;
      req_wdata[WB_MUL*DW +: DW] = 32'h0000_0077;
      #1 chk("sb_wb_ready", req_ready, 3'b100);
      cyc();
      req_valid = 3'b000;
      chk("sb_wb_wen", rf_wen, 1'b1);
      chk("sb_wb_waddr", rf_waddr, 5'd7);
      chk("sb_hazard_during", hazard1, 1'b1);
      cyc();
      chk("sb_hazard_after", hazard1, 1'b0);
      chk("sb_busy_after", busy, 32'h0);

      // Set/clear collision on r9; ptr is at 0.
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      cyc();
      issue_valid = 1'b0;
      req_valid   = 3'b001;
      req_waddr[WB_ALU*AW +: AW] = 5'd9;
      cyc();
      req_valid = 3'b000;
      chk("col_wen", rf_wen, 1'b1);
      chk("col_waddr", rf_waddr, 5'd9);
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      cyc();
      issue_valid = 1'b0;
      chk_raddr2  = 5'd9;
      #1;
      chk("col_hazard2", hazard2, 1'b1);
      chk("col_busy", busy, 32'h0000_0200);
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      chk_raddr1  = 5'd0;
      cyc();
      issue_valid = 1'b0;
      chk("x0_issue_busy", busy, 32'h0000_0200);
      chk("x0_hazard1", hazard1, 1'b0);

      // Reset while a write is in flight; ptr is at 1, LSU wins and ptr moves to 2.
      req_valid = 3'b010;
      cyc();
      req_valid = 3'b000;
      chk("mid_wen_before", rf_wen, 1'b1);
      chk("mid_waddr_before", rf_waddr, 5'd5);
      rst       = 1'b1;
      req_valid = 3'b111;
      #1 chk("mid_rst_ready", req_ready, 3'b000);
      cyc();
      chk("mid_wen_squash", rf_wen, 1'b0);
      chk("mid_waddr_rst", rf_waddr, 5'd0);
      chk("mid_busy_rst", busy, 32'h0);
      rst = 1'b0;
      #1 chk("mid_ptr_rst", req_ready, 3'b001);
      req_valid = 3'b000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
